// File: rtl/module_receptor_hamming.sv
// rtl/module_receptor_hamming.sv - serial frame receiver with Hamming(7,4) single-error correction
module module_receptor_hamming #(
    parameter int CLKS_POR_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [3:0] datos_out,
    output logic       valido,
    output logic       error_corregido,
    output logic [2:0] sindrome,
    output logic       error_trama
);

    localparam int CNT_W = $clog2(CLKS_POR_BIT);
    localparam logic [CNT_W-1:0] MEDIO = CNT_W'(CLKS_POR_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FIN   = CNT_W'(CLKS_POR_BIT - 1);

    typedef enum logic [2:0] {
        INACTIVO,
        INICIO,
        DATOS,
        PARADA,
        DECODIFICA
    } estado_t;

    estado_t          estado;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [6:0]       trama;
    logic             rx_meta;
    logic             rx_s;

    logic [2:0]       sind_c;
    logic [6:0]       mascara;
    logic [6:0]       cw_corr;
    logic [3:0]       datos_c;

    // Two-flop synchronizer; resets to the idle (high) line level so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // Syndrome and correction from the captured codeword; the codeword is complete before the stop sample
    always_comb begin
        sind_c[0] = trama[0] ^ trama[2] ^ trama[4] ^ trama[6];
        sind_c[1] = trama[1] ^ trama[2] ^ trama[5] ^ trama[6];
        sind_c[2] = trama[3] ^ trama[4] ^ trama[5] ^ trama[6];
        mascara   = (sind_c == 3'd0) ? 7'd0 : (7'd1 << (sind_c - 3'd1));
        cw_corr   = trama ^ mascara;
        datos_c   = {cw_corr[6], cw_corr[5], cw_corr[4], cw_corr[2]};
    end

    // Frame FSM; decoded results are registered at the stop-sample edge so valido appears in the following cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado          <= INACTIVO;
            cnt             <= '0;
            idx             <= '0;
            trama           <= '0;
            datos_out       <= '0;
            sindrome        <= '0;
            error_corregido <= 1'b0;
            valido          <= 1'b0;
            error_trama     <= 1'b0;
        end else begin
            valido      <= 1'b0;
            error_trama <= 1'b0;
            case (estado)
                INACTIVO: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx_s) begin
                        estado <= INICIO;
                    end
                end
                INICIO: begin
                    if (cnt == MEDIO) begin
                        cnt    <= '0;
                        estado <= rx_s ? INACTIVO : DATOS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATOS: begin
                    if (cnt == FIN) begin
                        cnt        <= '0;
                        trama[idx] <= rx_s;
                        if (idx == 3'd6) begin
                            estado <= PARADA;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARADA: begin
                    if (cnt == FIN) begin
                        cnt <= '0;
                        idx <= '0;
                        if (rx_s) begin
                            datos_out       <= datos_c;
                            sindrome        <= sind_c;
                            error_corregido <= (sind_c != 3'd0);
                            valido          <= 1'b1;
                            estado          <= DECODIFICA;
                        end else begin
                            error_trama <= 1'b1;
                            estado      <= INACTIVO;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DECODIFICA: begin
                    estado <= INACTIVO;
                end
                default: begin
                    estado <= INACTIVO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_receptor_hamming.sv
// tb/tb_module_receptor_hamming.sv - directed and exhaustive checks of the Hamming serial receiver
module tb_module_receptor_hamming;

    localparam int C = 16;
    localparam int H = C / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic [3:0] datos_out;
    logic       valido;
    logic       error_corregido;
    logic [2:0] sindrome;
    logic       error_trama;

    module_receptor_hamming #(.CLKS_POR_BIT(C)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_in           (rx_in),
        .datos_out       (datos_out),
        .valido          (valido),
        .error_corregido (error_corregido),
        .sindrome        (sindrome),
        .error_trama     (error_trama)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [2:0] s;
        logic       e;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   n_valido = 0;
    int   n_trama = 0;
    int   last_valido_cyc = -1;
    int   last_fall = 0;
    int   nv;
    int   nt;
    int   fall;
    logic [6:0] cw;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p0, p1, p2;
        p0 = d[0] ^ d[1] ^ d[3];
        p1 = d[0] ^ d[2] ^ d[3];
        p2 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p2, d[0], p1, p0};
    endfunction

    task push(input logic [3:0] d, input logic [2:0] s);
        exp_t e;
        e.d = d;
        e.s = s;
        e.e = (s != 3'd0);
        sb.push_back(e);
    endtask

    task send_bit(input logic b, input int n);
        rx_in = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task idle(input int n);
        send_bit(1'b1, n);
    endtask

    task send_frame(input logic [6:0] w, input logic stop_ok);
        last_fall = cyc;
        send_bit(1'b0, C);
        for (int i = 0; i < 7; i++) send_bit(w[i], C);
        if (stop_ok) begin
            send_bit(1'b1, C);
        end else begin
            send_bit(1'b0, H + 4);
            rx_in = 1'b1;
        end
    endtask

    // Scoreboard side: every valido pops one expected result
    always @(negedge clk) begin
        if (rst_n) begin
            if (error_trama) n_trama++;
            if (valido) begin
                n_valido++;
                last_valido_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_valido", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("datos_out", datos_out, mon_e.d);
                    chk("sindrome", sindrome, mon_e.s);
                    chk("error_corregido", error_corregido, mon_e.e);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_datos", datos_out, 0);
        chk("rst_sindrome", sindrome, 0);
        chk("rst_err_corr", error_corregido, 0);
        chk("rst_valido", valido, 0);
        chk("rst_trama", error_trama, 0);
        rst_n = 1'b1;
        idle(5);

        push(4'b1011, 3'd0);
        send_frame(7'b1010101, 1'b1);
        fall = last_fall;
        idle(4);
        chk("clean_latency", last_valido_cyc, fall + 3 + H + 8 * C);
        chk("clean_pulse_count", n_valido, 1);

        push(4'b1011, 3'd5);
        send_frame(7'b1000101, 1'b1);
        idle(4);
        push(4'b1011, 3'd1);
        send_frame(7'b1010100, 1'b1);
        idle(4);

        nv = n_valido;
        nt = n_trama;
        send_bit(1'b0, 4);
        idle(2 * C);
        chk("glitch_no_valido", n_valido, nv);
        chk("glitch_no_trama", n_trama, nt);

        send_frame(encode(4'b0110), 1'b0);
        idle(2 * C);
        chk("trama_pulse", n_trama, nt + 1);
        chk("trama_no_valido", n_valido, nv);
        chk("trama_hold_datos", datos_out, 4'b1011);
        chk("trama_hold_sindrome", sindrome, 3'd1);
        chk("trama_hold_err_corr", error_corregido, 1);

        push(4'b0110, 3'd0);
        send_frame(encode(4'b0110), 1'b1);
        idle(4);
        chk("after_trama_count", n_valido, nv + 1);

        cw = encode(4'b1101);
        send_bit(1'b0, C);
        for (int i = 0; i < 3; i++) send_bit(cw[i], C);
        send_bit(cw[3], H);
        rst_n = 1'b0;
        #1;
        chk("midrst_datos", datos_out, 0);
        chk("midrst_sindrome", sindrome, 0);
        chk("midrst_err_corr", error_corregido, 0);
        chk("midrst_valido", valido, 0);
        chk("midrst_trama", error_trama, 0);
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        nv = n_valido;
        nt = n_trama;
        idle(12 * C);
        chk("midrst_no_valido", n_valido, nv);
        chk("midrst_no_trama", n_trama, nt);
        push(4'b0000, 3'd0);
        send_frame(7'b0000000, 1'b1);
        idle(4);
        chk("postrst_count", n_valido, nv + 1);

        for (int d = 0; d < 16; d++) begin
            for (int p = 0; p < 8; p++) begin
                cw = encode(4'(d));
                if (p != 0) cw[p - 1] = ~cw[p - 1];
                push(4'(d), 3'(p));
                send_frame(cw, 1'b1);
            end
        end
        idle(2 * C);
        chk("sb_empty", sb.size(), 0);
        chk("hold_datos", datos_out, 4'd15);
        chk("hold_sindrome", sindrome, 3'd7);
        chk("hold_err_corr", error_corregido, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
